mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-port unified memory between instruction fetch (IF) and the LSU data port (MEM).
// - Arbitrates IF/MEM requests with data priority and an anti-starvation streak limit.
// - Issues one transaction at a time and routes each response back to its owner.
// - Drops fetches cancelled by taken branches/jumps (pc_sel) and reports memory timeouts.
// PARAMETERS
// - AW          32   address width (byte address)
// - MAX_D_STREAK 4   consecutive data grants allowed while a fetch waits
// - TIMEOUT     64   cycles in WAIT before the transaction is aborted
// PORTS
// i_clk        in  1   clock, rising edge
// i_reset      in  1   asynchronous, active-high reset
// i_if_req     in  1   fetch request (word read)
// i_if_addr    in  AW  fetch address
// i_if_flush   in  1   taken branch/jump: cancel pending/in-flight fetch
// o_if_gnt     out 1   fetch request accepted this cycle
// o_if_rvalid  out 1   fetch data valid (1-cycle pulse)
// o_if_rdata   out 32  fetched instruction
// i_d_req      in  1   data request
// i_d_we       in  1   1 = store, 0 = load
// i_d_be       in  4   byte enables (SB/SH/SW)
// i_d_addr     in  AW  data address
// i_d_wdata    in  32  store data
// o_d_gnt      out 1   data request accepted this cycle
// o_d_rvalid   out 1   load data / store ack valid (1-cycle pulse)
// o_d_rdata    out 32  load data (0 for stores)
// o_m_req      out 1   memory command strobe (1 cycle)
// o_m_we/o_m_be/o_m_addr/o_m_wdata  out 1/4/AW/32  registered memory command
// i_m_rvalid   in  1   memory response (reads and writes), latency >= 1 after o_m_req
// i_m_rdata    in  32  memory read data
// o_err        out 1   timeout pulse
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; streak counter, timeout counter, drop flag cleared. Async reset mid-transaction abandons it; a late i_m_rvalid after reset is ignored.
// - FSM IDLE -> ISSUE -> WAIT -> IDLE. One outstanding transaction only.
// - IDLE: gnt is combinational, only in IDLE. Winner = data if i_d_req, unless streak==MAX_D_STREAK and fetch eligible. Fetch eligible = i_if_req & ~i_if_flush. Winner's command is latched into o_m_*; go to ISSUE.
// - ISSUE: o_m_req=1 for exactly this cycle; go to WAIT; clear the timeout counter.
// - WAIT: on i_m_rvalid, register rdata and pulse the owner's rvalid on the next cycle; go to IDLE. IDLE may grant in that same rvalid cycle.
// - Fastest turnaround: gnt@T, o_m_req@T+1, i_m_rvalid@T+2, o_x_rvalid and next gnt@T+3.
// - Streak: increments on a data grant while fetch is eligible. Clears on a fetch grant or when fetch is not eligible. Saturates at MAX_D_STREAK.
// - Flush: i_if_flush while IF owns ISSUE/WAIT sets drop. The response is consumed, o_if_rvalid is suppressed, drop clears.
// - Flush in the o_if_rvalid cycle has no effect (already delivered). Flush never affects data transactions.
// - Timeout: counter reaches TIMEOUT in WAIT -> o_err pulse, owner rvalid pulse with rdata=0 (suppressed if drop), go to IDLE. i_m_rvalid outside WAIT is ignored.
// - Simultaneous i_m_rvalid and timeout in the same cycle: the response wins, no o_err.
// - o_m_addr/wdata/be/we hold their last values outside ISSUE; o_d_rdata=0 for store acks.
// STRUCTURE
// - Shared package: arb_state_e {IDLE, ISSUE, WAIT} and arb_owner_e {OWN_IF, OWN_D}.
// - Width constants live in the core package.
// - Sub-module: mem_arb_pick (combinational winner and streak next-state).
// - Everything else is inline: FSM, command/response registers, counters.
// TESTING
// 1. Fetch only, addr 0x100, mem latency 1 -> o_m_req@T+1, o_if_rvalid@T+3, rdata equals memory word.
// 2. i_if_req and i_d_req high continuously (latency 1) -> grant order D,D,D,D,IF,D,D,D,D,IF.
// 3. Store be=4'b0011, addr 0x204, wdata 0xDEAD_BEEF -> o_m_we=1, be=3; o_d_rvalid pulses, o_d_rdata=0.
// 4. Fetch granted, latency 5, i_if_flush at T+2 -> no o_if_rvalid; next fetch is granted after the response.
// 5. No i_m_rvalid for 64 cycles -> o_err pulse plus owner rvalid (rdata=0), FSM back in IDLE.
// 6. i_reset asserted in WAIT, then late i_m_rvalid -> ignored; all outputs 0; next request served normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and width constants for the IF/LSU unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DW  = 32;
  localparam int BEW = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  // Response payload: stores and timed-out transactions return zero.
  function automatic logic [DW-1:0] resp_data(input logic zero_it, input logic [DW-1:0] rdata);
    return zero_it ? {DW{1'b0}} : rdata;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter, named from the arbiter's point of view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = 32
);

  logic           i_if_req;
  logic [AW-1:0]  i_if_addr;
  logic           i_if_flush;
  logic           o_if_gnt;
  logic           o_if_rvalid;
  logic [DW-1:0]  o_if_rdata;

  logic           i_d_req;
  logic           i_d_we;
  logic [BEW-1:0] i_d_be;
  logic [AW-1:0]  i_d_addr;
  logic [DW-1:0]  i_d_wdata;
  logic           o_d_gnt;
  logic           o_d_rvalid;
  logic [DW-1:0]  o_d_rdata;

  logic           o_m_req;
  logic           o_m_we;
  logic [BEW-1:0] o_m_be;
  logic [AW-1:0]  o_m_addr;
  logic [DW-1:0]  o_m_wdata;
  logic           i_m_rvalid;
  logic [DW-1:0]  i_m_rdata;

  logic           o_err;

  modport slave (
    input  i_if_req, i_if_addr, i_if_flush,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
    output o_d_gnt, o_d_rvalid, o_d_rdata,
    output o_m_req, o_m_we, o_m_be, o_m_addr, o_m_wdata,
    input  i_m_rvalid, i_m_rdata,
    output o_err
  );

  modport master (
    output i_if_req, i_if_addr, i_if_flush,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
    input  o_d_gnt, o_d_rvalid, o_d_rdata,
    input  o_m_req, o_m_we, o_m_be, o_m_addr, o_m_wdata,
    output i_m_rvalid, i_m_rdata,
    input  o_err
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational IF/data winner selection with the data-streak limit, plus streak next-state.
module mem_arb_pick #(
  parameter int MAX_D_STREAK = 4,
  parameter int SW           = 3
) (
  input  logic          i_idle,
  input  logic          i_if_req,
  input  logic          i_if_flush,
  input  logic          i_d_req,
  input  logic [SW-1:0] i_streak,
  output logic          o_if_win,
  output logic          o_d_win,
  output logic [SW-1:0] o_streak_d
);

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  logic fetch_elig;
  logic fetch_due;

  assign fetch_elig = i_if_req & ~i_if_flush;
  assign fetch_due  = fetch_elig & (i_streak == STREAK_MAX);

  // Data wins unless a waiting fetch has already been passed over MAX_D_STREAK times.
  always_comb begin
    o_if_win = 1'b0;
    o_d_win  = 1'b0;
    if (!i_idle) begin
      o_if_win = 1'b0;
      o_d_win  = 1'b0;
    end else if (i_d_req && !fetch_due) begin
      o_d_win = 1'b1;
    end else if (fetch_elig) begin
      o_if_win = 1'b1;
    end else begin
      o_if_win = 1'b0;
      o_d_win  = 1'b0;
    end
  end

  // Streak only counts data grants that a live fetch actually had to wait behind.
  always_comb begin
    o_streak_d = i_streak;
    if (!fetch_elig || o_if_win) begin
      o_streak_d = {SW{1'b0}};
    end else if (o_d_win && (i_streak != STREAK_MAX)) begin
      o_streak_d = i_streak + STREAK_ONE;
    end else begin
      o_streak_d = i_streak;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the LSU: one transaction in
// flight, responses routed to their owner, cancelled fetches dropped, timeouts reported.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input logic              i_clk,
  input logic              i_reset,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  arb_state_e     state_q,     state_d;
  arb_owner_e     owner_q,     owner_d;
  logic [SW-1:0]  streak_q,    streak_d;
  logic [TW-1:0]  tmo_q,       tmo_d;
  logic           drop_q,      drop_d;
  logic           m_req_q,     m_req_d;
  logic           m_we_q,      m_we_d;
  logic [BEW-1:0] m_be_q,      m_be_d;
  logic [AW-1:0]  m_addr_q,    m_addr_d;
  logic [DW-1:0]  m_wdata_q,   m_wdata_d;
  logic           if_rvalid_q, if_rvalid_d;
  logic [DW-1:0]  if_rdata_q,  if_rdata_d;
  logic           d_rvalid_q,  d_rvalid_d;
  logic [DW-1:0]  d_rdata_q,   d_rdata_d;
  logic           err_q,       err_d;

  logic if_win;
  logic d_win;
  logic if_flush_hit;
  logic drop_eff;
  logic timed_out;
  logic resp_done;

  mem_arb_pick #(
    .MAX_D_STREAK (MAX_D_STREAK),
    .SW           (SW)
  ) u_pick (
    .i_idle     (state_q == IDLE),
    .i_if_req   (bus.i_if_req),
    .i_if_flush (bus.i_if_flush),
    .i_d_req    (bus.i_d_req),
    .i_streak   (streak_q),
    .o_if_win   (if_win),
    .o_d_win    (d_win),
    .o_streak_d (streak_d)
  );

  // A flush landing in the very cycle the response arrives must still suppress it.
  assign if_flush_hit = (owner_q == OWN_IF) & bus.i_if_flush;
  assign drop_eff     = drop_q | if_flush_hit;
  assign timed_out    = ~bus.i_m_rvalid & (tmo_q == TMO_LAST);
  assign resp_done    = bus.i_m_rvalid | timed_out;

  // Next-state logic for the IDLE/ISSUE/WAIT sequencer, command and response registers.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    tmo_d       = tmo_q;
    drop_d      = drop_q;
    m_req_d     = 1'b0;
    m_we_d      = m_we_q;
    m_be_d      = m_be_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_win) begin
          owner_d   = OWN_D;
          m_we_d    = bus.i_d_we;
          m_be_d    = bus.i_d_be;
          m_addr_d  = bus.i_d_addr;
          m_wdata_d = bus.i_d_wdata;
          m_req_d   = 1'b1;
          state_d   = ISSUE;
        end else if (if_win) begin
          owner_d   = OWN_IF;
          m_we_d    = 1'b0;
          m_be_d    = {BEW{1'b1}};
          m_addr_d  = bus.i_if_addr;
          m_wdata_d = {DW{1'b0}};
          m_req_d   = 1'b1;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        tmo_d   = {TW{1'b0}};
        drop_d  = drop_eff;
      end
      WAIT: begin
        if (resp_done) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          err_d   = timed_out;
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = resp_data(m_we_q | timed_out, bus.i_m_rdata);
          end else if (!drop_eff) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = resp_data(timed_out, bus.i_m_rdata);
          end else begin
            if_rvalid_d = 1'b0;
          end
        end else begin
          tmo_d  = tmo_q + TMO_ONE;
          drop_d = drop_eff;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      streak_q    <= {SW{1'b0}};
      tmo_q       <= {TW{1'b0}};
      drop_q      <= 1'b0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_be_q      <= {BEW{1'b0}};
      m_addr_q    <= {AW{1'b0}};
      m_wdata_q   <= {DW{1'b0}};
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= {DW{1'b0}};
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= {DW{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      drop_q      <= drop_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_be_q      <= m_be_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_if_gnt    = if_win;
  assign bus.o_d_gnt     = d_win;
  assign bus.o_if_rvalid = if_rvalid_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_d_rvalid  = d_rvalid_q;
  assign bus.o_d_rdata   = d_rdata_q;
  assign bus.o_m_req     = m_req_q;
  assign bus.o_m_we      = m_we_q;
  assign bus.o_m_be      = m_be_q;
  assign bus.o_m_addr    = m_addr_q;
  assign bus.o_m_wdata   = m_wdata_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory answers commands and
// expected responses are queued per port as requests are accepted.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   err_cnt = 0;
  int   lat = 1;
  bit   mem_mute = 1'b0;

  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] ref_mem[logic [29:0]];
  logic [31:0] phys_mem[logic [29:0]];

  mem_port_arbiter_if #(.AW(32)) bus ();

  mem_port_arbiter #(
    .AW           (32),
    .MAX_D_STREAK (4),
    .TIMEOUT      (64)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return mem_init(a);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    if (phys_mem.exists(a[31:2])) return phys_mem[a[31:2]];
    return mem_init(a);
  endfunction

  task automatic push_expect(input bit is_d, input bit we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata);
    if (is_d && we) begin
      ref_mem[addr[31:2]] = merge(ref_rd(addr), be, wdata);
      exp_d_q.push_back(32'h0);
    end else if (is_d) begin
      exp_d_q.push_back(ref_rd(addr));
    end else begin
      exp_if_q.push_back(ref_rd(addr));
    end
  endtask

  task automatic do_req(input bit is_d, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit push_exp,
                        output int gnt_cyc, output int gnt_lat);
    int  start;
    bit  got;
    @(posedge clk); #1;
    start = cyc; got = 1'b0; gnt_cyc = 0; gnt_lat = -1;
    if (is_d) begin
      bus.i_d_req = 1'b1; bus.i_d_we = we; bus.i_d_be = be;
      bus.i_d_addr = addr; bus.i_d_wdata = wdata;
    end else begin
      bus.i_if_req = 1'b1; bus.i_if_addr = addr;
    end
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if ((is_d && bus.o_d_gnt) || (!is_d && bus.o_if_gnt)) begin
        got = 1'b1; gnt_cyc = cyc; gnt_lat = cyc - start;
        if (push_exp) push_expect(is_d, we, be, addr, wdata);
      end
    end
    if (!got) chk("gnt_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.i_d_req = 1'b0; bus.i_if_req = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (exp_if_q.size() != 0 || exp_d_q.size() != 0); k++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_m_req"},  {31'h0, bus.o_m_req},     32'h0);
    chk({t, "_m_we"},   {31'h0, bus.o_m_we},      32'h0);
    chk({t, "_m_be"},   {28'h0, bus.o_m_be},      32'h0);
    chk({t, "_m_addr"}, bus.o_m_addr,             32'h0);
    chk({t, "_m_wd"},   bus.o_m_wdata,            32'h0);
    chk({t, "_if_rv"},  {31'h0, bus.o_if_rvalid}, 32'h0);
    chk({t, "_if_rd"},  bus.o_if_rdata,           32'h0);
    chk({t, "_d_rv"},   {31'h0, bus.o_d_rvalid},  32'h0);
    chk({t, "_d_rd"},   bus.o_d_rdata,            32'h0);
    chk({t, "_err"},    {31'h0, bus.o_err},       32'h0);
    chk({t, "_if_gnt"}, {31'h0, bus.o_if_gnt},    32'h0);
    chk({t, "_d_gnt"},  {31'h0, bus.o_d_gnt},     32'h0);
  endtask

  // Behavioural memory: captures each command strobe and answers after 'lat' cycles.
  initial begin : responder
    logic [31:0] r_addr, r_data;
    bus.i_m_rvalid = 1'b0;
    bus.i_m_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.o_m_req === 1'b1 && !mem_mute) begin
        r_addr = bus.o_m_addr;
        if (bus.o_m_we) begin
          phys_mem[r_addr[31:2]] = merge(phys_rd(r_addr), bus.o_m_be, bus.o_m_wdata);
          r_data = 32'hFFFF_FFFF;
        end else begin
          r_data = phys_rd(r_addr);
        end
        repeat (lat - 1) @(negedge clk);
        @(posedge clk); #1;
        bus.i_m_rvalid = 1'b1; bus.i_m_rdata = r_data;
        @(posedge clk); #1;
        bus.i_m_rvalid = 1'b0; bus.i_m_rdata = 32'h0;
      end
    end
  end

  // Response monitor: every rvalid pulse must match the head of its port's queue.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.o_if_rvalid === 1'b1) begin
        if (exp_if_q.size() == 0) chk("if_rv_unexp", 32'd1, 32'd0);
        else chk("if_rdata", bus.o_if_rdata, exp_if_q.pop_front());
      end
      if (bus.o_d_rvalid === 1'b1) begin
        if (exp_d_q.size() == 0) chk("d_rv_unexp", 32'd1, 32'd0);
        else chk("d_rdata", bus.o_d_rdata, exp_d_q.pop_front());
      end
      if (bus.o_err === 1'b1) err_cnt++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int    t, g, gl, n_gnt, l;
    bit    seen;
    byte   ord[10];
    string exp_ord;

    bus.i_if_req = 1'b0; bus.i_if_addr = 32'h0; bus.i_if_flush = 1'b0;
    bus.i_d_req = 1'b0; bus.i_d_we = 1'b0; bus.i_d_be = 4'h0;
    bus.i_d_addr = 32'h0; bus.i_d_wdata = 32'h0;
    for (int i = 0; i < 10; i++) ord[i] = 8'h0;

    repeat (3) @(posedge clk); #1;
    chk_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("post_rst");

    // 1: single fetch, latency 1
    lat = 1;
    do_req(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b1, t, gl);
    @(negedge clk);
    chk("t1_m_req",  {31'h0, bus.o_m_req}, 32'h1);
    chk("t1_m_addr", bus.o_m_addr, 32'h100);
    chk("t1_m_we",   {31'h0, bus.o_m_we}, 32'h0);
    seen = 1'b0; l = -1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.o_if_rvalid) begin seen = 1'b1; l = cyc - t; end
    end
    chk("t1_rv_lat", l, 32'd3);
    drain();

    // 2: both ports requesting continuously
    @(posedge clk); #1;
    bus.i_d_req = 1'b1; bus.i_d_we = 1'b0; bus.i_d_be = 4'hF; bus.i_d_addr = 32'h500;
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h600;
    n_gnt = 0;
    for (int k = 0; k < 300 && n_gnt < 10; k++) begin
      @(negedge clk);
      if (bus.o_d_gnt) begin
        push_expect(1'b1, 1'b0, 4'hF, 32'h500, 32'h0); ord[n_gnt] = "D"; n_gnt++;
      end else if (bus.o_if_gnt) begin
        push_expect(1'b0, 1'b0, 4'hF, 32'h600, 32'h0); ord[n_gnt] = "I"; n_gnt++;
      end
    end
    @(posedge clk); #1;
    bus.i_d_req = 1'b0; bus.i_if_req = 1'b0;
    exp_ord = "DDDDIDDDDI";
    for (int i = 0; i < 10; i++) chk($sformatf("t2_order%0d", i), {24'h0, ord[i]}, {24'h0, exp_ord[i]});
    drain();

    // 3: half-word store, then read back
    do_req(1'b1, 1'b1, 4'b0011, 32'h204, 32'hDEAD_BEEF, 1'b1, t, gl);
    @(negedge clk);
    chk("t3_m_req",   {31'h0, bus.o_m_req}, 32'h1);
    chk("t3_m_we",    {31'h0, bus.o_m_we}, 32'h1);
    chk("t3_m_be",    {28'h0, bus.o_m_be}, 32'h3);
    chk("t3_m_addr",  bus.o_m_addr, 32'h204);
    chk("t3_m_wdata", bus.o_m_wdata, 32'hDEAD_BEEF);
    drain();
    do_req(1'b1, 1'b0, 4'hF, 32'h204, 32'h0, 1'b1, t, gl);
    drain();

    // 4: fetch cancelled while waiting on a slow memory
    lat = 5;
    do_req(1'b0, 1'b0, 4'hF, 32'h700, 32'h0, 1'b0, t, gl);
    @(posedge clk); #1;
    bus.i_if_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_if_flush = 1'b0;
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h704;
    g = -1;
    for (int k = 0; k < 50 && g < 0; k++) begin
      @(negedge clk);
      if (bus.o_if_gnt) begin g = cyc; push_expect(1'b0, 1'b0, 4'hF, 32'h704, 32'h0); end
    end
    @(posedge clk); #1;
    bus.i_if_req = 1'b0;
    chk("t4_regnt_cyc", g - t, 32'd7);
    drain();

    // 5: memory never answers
    lat = 1;
    mem_mute = 1'b1;
    do_req(1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0, t, gl);
    exp_d_q.push_back(32'h0);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (bus.o_err) begin
        seen = 1'b1;
        chk("t5_d_rvalid", {31'h0, bus.o_d_rvalid}, 32'h1);
        chk("t5_err_lat_ok", {31'h0, ((cyc - t) >= 65 && (cyc - t) <= 67)}, 32'h1);
      end
    end
    chk("t5_err_seen", {31'h0, seen}, 32'h1);
    mem_mute = 1'b0;
    do_req(1'b0, 1'b0, 4'hF, 32'h104, 32'h0, 1'b1, t, gl);
    chk("t5_idle_gnt", gl, 32'd0);
    drain();

    // 6: reset while waiting, late response must be ignored
    lat = 6;
    do_req(1'b0, 1'b0, 4'hF, 32'h400, 32'h0, 1'b0, t, gl);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_zero("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    lat = 1;
    do_req(1'b0, 1'b0, 4'hF, 32'h404, 32'h0, 1'b1, t, gl);
    chk("t6_gnt_lat", gl, 32'd0);
    do_req(1'b1, 1'b0, 4'hF, 32'h204, 32'h0, 1'b1, t, gl);
    drain();

    chk("err_count",  err_cnt, 32'd1);
    chk("if_q_empty", exp_if_q.size(), 32'd0);
    chk("d_q_empty",  exp_d_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
